// File: rtl/dijkstra_controller_if.sv
`default_nettype none
// ============================================================================
// Module  : dijkstra_controller_if
// Brief   : Host, adjacency, distance/min store and VisitedStore signals
//           seen by the Dijkstra sequencing controller.
// Rev     : 1.0
// ============================================================================
interface dijkstra_controller_if #(
  parameter int INDEX_WIDTH = 8,
  parameter int VALUE_WIDTH = 16
);
  // host side
  logic                   start;
  logic [INDEX_WIDTH-1:0] number_of_nodes;
  logic [INDEX_WIDTH-1:0] source_node;
  logic                   busy;
  logic                   done;
  logic                   error;

  // adjacency memory
  logic [INDEX_WIDTH-1:0] adj_row;
  logic [INDEX_WIDTH-1:0] adj_col;
  logic [VALUE_WIDTH-1:0] adj_weight;

  // distance / min store
  logic [INDEX_WIDTH-1:0] dist_rd_index;
  logic [VALUE_WIDTH-1:0] dist_rd_value;
  logic                   dist_wr_en;
  logic [INDEX_WIDTH-1:0] dist_wr_index;
  logic [VALUE_WIDTH-1:0] dist_wr_value;
  logic [INDEX_WIDTH-1:0] dist_wr_prev;
  logic                   dist_retire_en;
  logic [INDEX_WIDTH-1:0] min_index;
  logic [VALUE_WIDTH-1:0] min_value;
  logic [INDEX_WIDTH-1:0] min_prev;

  // VisitedStore
  logic                   vs_set_en;
  logic [INDEX_WIDTH-1:0] vs_index;
  logic [INDEX_WIDTH-1:0] vs_prev_node;
  logic [INDEX_WIDTH-1:0] unvisited_nodes;

  modport master (
    input  start, number_of_nodes, source_node,
    input  adj_weight, dist_rd_value,
    input  min_index, min_value, min_prev, unvisited_nodes,
    output busy, done, error,
    output adj_row, adj_col, dist_rd_index,
    output dist_wr_en, dist_wr_index, dist_wr_value, dist_wr_prev,
    output dist_retire_en,
    output vs_set_en, vs_index, vs_prev_node
  );

  modport slave (
    output start, number_of_nodes, source_node,
    output adj_weight, dist_rd_value,
    output min_index, min_value, min_prev, unvisited_nodes,
    input  busy, done, error,
    input  adj_row, adj_col, dist_rd_index,
    input  dist_wr_en, dist_wr_index, dist_wr_value, dist_wr_prev,
    input  dist_retire_en,
    input  vs_set_en, vs_index, vs_prev_node
  );
endinterface
`default_nettype wire

// File: rtl/dijkstra_controller.sv
`default_nettype none
// ============================================================================
// Module  : dijkstra_controller
// Brief   : Sequencing FSM of the Dijkstra engine: init, select, visit and a
//           two-stage relax scan over the adjacency row of the visited node.
// Rev     : 1.0
// ============================================================================
module dijkstra_controller #(
  parameter int MAX_NODES   = 256,
  parameter int INDEX_WIDTH = 8,
  parameter int VALUE_WIDTH = 16
) (
  input  wire logic             clock,
  input  wire logic             reset,
  dijkstra_controller_if.master bus
);

  // The counter must reach N (drain cycle), so it is one bit wider than an index.
  localparam int c_cnt_w = ($clog2(MAX_NODES + 1) > INDEX_WIDTH) ?
                           $clog2(MAX_NODES + 1) : INDEX_WIDTH + 1;
  localparam logic [VALUE_WIDTH-1:0] c_inf = '1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_SELECT = 3'd2,
    S_VISIT  = 3'd3,
    S_SCAN   = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                 state_q,    state_d;
  logic [INDEX_WIDTH-1:0] n_q,        n_d;
  logic [INDEX_WIDTH-1:0] src_q,      src_d;
  logic [INDEX_WIDTH-1:0] cur_q,      cur_d;
  logic [VALUE_WIDTH-1:0] cur_dist_q, cur_dist_d;
  logic [c_cnt_w-1:0]     cnt_q,      cnt_d;
  logic                   err_q,      err_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [INDEX_WIDTH-1:0] s2_col_q,   s2_col_d;

  logic [c_cnt_w-1:0]     w_n_ext;
  logic [INDEX_WIDTH-1:0] w_idx;
  logic                   w_init_last;
  logic                   w_issue;
  logic                   w_scan_end;
  logic [VALUE_WIDTH:0]   w_sum;
  logic                   w_relax;
  logic                   w_start_err;

  assign w_n_ext     = c_cnt_w'(n_q);
  assign w_idx       = cnt_q[INDEX_WIDTH-1:0];
  assign w_init_last = (cnt_q == (w_n_ext - c_cnt_w'(1)));
  assign w_issue     = (cnt_q < w_n_ext);
  assign w_scan_end  = (cnt_q == w_n_ext);
  assign w_start_err = (bus.number_of_nodes == '0) ||
                       (bus.source_node >= bus.number_of_nodes);

  // Stage 2 of the scan: data for column s2_col_q arrives one cycle after issue.
  assign w_sum   = {1'b0, cur_dist_q} + {1'b0, bus.adj_weight};
  assign w_relax = (state_q == S_SCAN) && s2_valid_q &&
                   (bus.adj_weight != '0) &&
                   (s2_col_q != cur_q) &&
                   (w_sum < {1'b0, c_inf}) &&
                   (w_sum < {1'b0, bus.dist_rd_value});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      n_q        <= '0;
      src_q      <= '0;
      cur_q      <= '0;
      cur_dist_q <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_col_q   <= '0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      src_q      <= src_d;
      cur_q      <= cur_d;
      cur_dist_q <= cur_dist_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      s2_valid_q <= s2_valid_d;
      s2_col_q   <= s2_col_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    src_d      = src_q;
    cur_d      = cur_q;
    cur_dist_d = cur_dist_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    s2_valid_d = 1'b0;
    s2_col_d   = s2_col_q;

    bus.busy           = 1'b0;
    bus.done           = 1'b0;
    bus.error          = 1'b0;
    bus.adj_row        = '0;
    bus.adj_col        = '0;
    bus.dist_rd_index  = '0;
    bus.dist_wr_en     = 1'b0;
    bus.dist_wr_index  = '0;
    bus.dist_wr_value  = '0;
    bus.dist_wr_prev   = '0;
    bus.dist_retire_en = 1'b0;
    bus.vs_set_en      = 1'b0;
    bus.vs_index       = '0;
    bus.vs_prev_node   = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          n_d     = bus.number_of_nodes;
          src_d   = bus.source_node;
          cur_d   = bus.source_node;
          cnt_d   = '0;
          err_d   = w_start_err;
          state_d = w_start_err ? S_DONE : S_INIT;
        end
      end

      S_INIT: begin
        bus.busy          = 1'b1;
        bus.dist_wr_en    = 1'b1;
        bus.dist_wr_index = w_idx;
        bus.dist_wr_value = (w_idx == src_q) ? '0 : c_inf;
        bus.dist_wr_prev  = w_idx;
        cnt_d             = cnt_q + c_cnt_w'(1);
        if (w_init_last) begin
          state_d = S_SELECT;
        end
      end

      S_SELECT: begin
        bus.busy = 1'b1;
        state_d  = S_VISIT;
      end

      S_VISIT: begin
        bus.busy = 1'b1;
        if ((bus.unvisited_nodes == '0) || (bus.min_value == c_inf)) begin
          state_d = S_DONE;
        end else begin
          bus.vs_set_en      = 1'b1;
          bus.vs_index       = bus.min_index;
          bus.vs_prev_node   = bus.min_prev;
          bus.dist_retire_en = 1'b1;
          cur_d              = bus.min_index;
          cur_dist_d         = bus.min_value;
          cnt_d              = '0;
          state_d            = S_SCAN;
        end
      end

      S_SCAN: begin
        bus.busy = 1'b1;
        if (w_issue) begin
          bus.adj_row       = cur_q;
          bus.adj_col       = w_idx;
          bus.dist_rd_index = w_idx;
          s2_valid_d        = 1'b1;
          s2_col_d          = w_idx;
        end
        if (w_relax) begin
          bus.dist_wr_en    = 1'b1;
          bus.dist_wr_index = s2_col_q;
          bus.dist_wr_value = w_sum[VALUE_WIDTH-1:0];
          bus.dist_wr_prev  = cur_q;
        end
        cnt_d = cnt_q + c_cnt_w'(1);
        if (w_scan_end) begin
          state_d = S_SELECT;
        end
      end

      S_DONE: begin
        bus.done  = 1'b1;
        bus.error = err_q;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: doc/dijkstra_controller.md
# dijkstra_controller

Sequencing FSM for the Dijkstra shortest-path engine. On `start` it initialises the distance store, repeatedly takes the minimum-distance unretired node, commits it to VisitedStore with its predecessor, and relaxes its outgoing edges read from the adjacency memory. It sits between the top-level host interface and the three storage blocks: adjacency memory, distance/min store and VisitedStore. It owns every write-enable into those blocks.

## Interface
- `MAX_NODES`, 256, node capacity.
- `INDEX_WIDTH`, 8, node index width.
- `VALUE_WIDTH`, 16, distance/weight width. INF = all-ones.

- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset asserted).
- `start`  in  1  run request; sampled only in IDLE.
- `number_of_nodes`  in  INDEX_WIDTH  N; sampled with `start`.
- `source_node`  in  INDEX_WIDTH  source; sampled with `start`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse at end of run.
- `error`  out  1  valid with `done`; high when N==0 or source>=N.
- `adj_row`, `adj_col`  out  INDEX_WIDTH  adjacency read address.
- `adj_weight`  in  VALUE_WIDTH  edge weight, 1-cycle read latency; 0 = no edge.
- `dist_rd_index`  out  INDEX_WIDTH  distance read address.
- `dist_rd_value`  in  VALUE_WIDTH  distance read data, 1-cycle latency.
- `dist_wr_en`, `dist_wr_index`, `dist_wr_value`, `dist_wr_prev`  out  1/INDEX/VALUE/INDEX  distance+prev write.
- `dist_retire_en`  out  1  removes `min_index` from the min search.
- `min_index`, `min_value`, `min_prev`  in  INDEX/VALUE/INDEX  combinational minimum over unretired entries below N.
- `vs_set_en`, `vs_index`, `vs_prev_node`  out  1/INDEX/INDEX  VisitedStore commit.
- `unvisited_nodes`  in  INDEX_WIDTH  count from VisitedStore.

## Operation
- States: IDLE, INIT, SELECT, VISIT, SCAN, DONE.
- IDLE: on `start`, latch N, source and `cur`.
  - Go to DONE with the error flag set if N==0 or source>=N.
  - Otherwise go to INIT.
- INIT: a counter i runs 0..N-1, one write per cycle.
  - `dist_wr_value` = 0 when i==source, else INF.
  - `dist_wr_prev` = i.
  - After i==N-1, go to SELECT.
- SELECT: one settle cycle for the min store. Go to VISIT.
- VISIT:
  - If `unvisited_nodes`==0 or `min_value`==INF, go to DONE with no writes.
  - Otherwise, in one cycle: pulse `vs_set_en` with `vs_index`=`min_index` and `vs_prev_node`=`min_prev`; pulse `dist_retire_en`; latch `cur`=`min_index` and `cur_dist`=`min_value`. Go to SCAN.
- SCAN is a 2-stage pipeline. Column c = 0..N-1 is issued one per cycle: `adj_row`=`cur`, `adj_col`=c, `dist_rd_index`=c.
- Stage 2 (next cycle) computes `sum` = `cur_dist` + `adj_weight` in VALUE_WIDTH+1 bits. It writes dist[c]=`sum`[VALUE_WIDTH-1:0] with prev=`cur` only when all of these hold:
  - `adj_weight` != 0;
  - c != `cur`;
  - `sum` < INF, so no overflow or saturation;
  - `sum` < `dist_rd_value` (strictly less; ties keep the old prev).
- SCAN lasts N+1 cycles: the issue cycles plus a drain cycle. Then go to SELECT.
- Consecutive writes and reads target different columns, so no forwarding is needed.
- DONE: `done`=1 for one cycle, `error` as latched. Then go to IDLE.
- `start` while `busy` is ignored.
- Reset asserted mid-run:
  - All outputs go to 0 immediately and the state goes to IDLE.
  - The stores are reset by the same net. The controller does not clear them.

## Timing
- Reset values: every output 0, including `busy`, `done`, `error`, all enables and all addresses.
- `start` is sampled at edge k. `busy`=1 from k+1. INIT writes occur on cycles k+1..k+N.
- Each visited node costs N+3 cycles: SELECT 1, VISIT 1, SCAN N+1.
- With R reachable nodes and R<N, the terminating SELECT+VISIT adds 2 cycles. `done` is asserted on the following cycle and `busy` drops with it.
- With R==N, termination happens via `unvisited_nodes`==0, with the same cycle count.
- Error path: `done` and `error` are high at cycle k+1. No store writes occur.
- Enables are single-cycle pulses, never held.

## Test plan
- Test 1, 4-node graph: N=4, source=0, edges 0→1:5, 0→2:1, 2→1:2, 1→3:1.
  - Visit order 0, 2, 1, 3.
  - Distances 0, 3, 1, 4; prev 0, 2, 0, 1.
  - `done` exactly 4+4·7+2+1 cycles after `start`.
- Test 2, unreachable nodes: N=3, source=0, edge 0→1:7 only.
  - Nodes 0 and 1 visited; `unvisited_nodes`=1 at `done`; dist[2] stays INF; `error`=0.
- Test 3, overflow: N=2, dist source=0, edge 0→1 weight 0xFFFF.
  - `sum` equals INF, so there is no write. Node 1 is never visited.
- Test 4, error path: `start` with N=0 and, separately, with source=5, N=4.
  - `done`=`error`=1 one cycle after `start`; no enables pulse.
- Test 5, reset mid-run: drive `reset`=0 asynchronously during SCAN.
  - All outputs 0 before the next clock edge.
  - After release, a new `start` reruns Test 1 with identical results.
- Test 6, `start` while busy: pulse `start` during a run.
  - The pulse is ignored: no restart, single `done`.
